// File: rtl/ysyx_22040632_mem_arbiter.sv
// Round-robin arbiter sharing the single memory-bus master port between I-cache refill
// and D-cache traffic; one transaction is outstanding at a time.
module ysyx_22040632_mem_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int BEATS = 4
) (
    input  logic            clk,
    input  logic            rrst_n,
    input  logic            ic_valid,
    input  logic [AW-1:0]   ic_addr,
    output logic            ic_ready,
    output logic            ic_rvalid,
    input  logic            dc_valid,
    input  logic            dc_req,
    input  logic            dc_burst,
    input  logic [AW-1:0]   dc_addr,
    input  logic [DW-1:0]   dc_wdata,
    input  logic [DW/8-1:0] dc_wstrb,
    output logic            dc_ready,
    output logic            dc_rvalid,
    output logic            dc_bvalid,
    output logic            bus_valid,
    input  logic            bus_ready,
    output logic            bus_req,
    output logic [AW-1:0]   bus_addr,
    output logic [7:0]      bus_len,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    input  logic            bus_rvalid,
    input  logic            bus_rlast,
    input  logic            bus_bvalid
);

    localparam int   LW       = $clog2(BEATS + 1);
    localparam logic OWN_IC   = 1'b0;
    localparam logic OWN_DC   = 1'b1;
    localparam logic [7:0] BURST_LEN = 8'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        RDATA = 2'd2,
        WRESP = 2'd3
    } state_t;

    state_t            state_r;
    logic              owner_r;
    logic              last_gnt_r;
    logic              req_r;
    logic [AW-1:0]     addr_r;
    logic [7:0]        len_r;
    logic [DW-1:0]     wdata_r;
    logic [DW/8-1:0]   wstrb_r;
    logic [LW-1:0]     beat_cnt_r;
    logic              gnt_ic_s;
    logic              gnt_dc_s;

    // Grant decision: only in IDLE; on contention the side not served last wins.
    always_comb begin
        gnt_ic_s = 1'b0;
        gnt_dc_s = 1'b0;
        if (state_r == IDLE) begin
            if (ic_valid && dc_valid) begin
                if (last_gnt_r == OWN_DC) begin
                    gnt_ic_s = 1'b1;
                end else begin
                    gnt_dc_s = 1'b1;
                end
            end else if (ic_valid) begin
                gnt_ic_s = 1'b1;
            end else if (dc_valid) begin
                gnt_dc_s = 1'b1;
            end else begin
                gnt_ic_s = 1'b0;
                gnt_dc_s = 1'b0;
            end
        end else begin
            gnt_ic_s = 1'b0;
            gnt_dc_s = 1'b0;
        end
    end

    // Transaction FSM with latched request fields; a response outside its state is ignored.
    always_ff @(posedge clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r    <= IDLE;
            owner_r    <= OWN_IC;
            last_gnt_r <= OWN_DC;
            req_r      <= 1'b0;
            addr_r     <= {AW{1'b0}};
            len_r      <= 8'd0;
            wdata_r    <= {DW{1'b0}};
            wstrb_r    <= {(DW/8){1'b0}};
            beat_cnt_r <= {LW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_ic_s) begin
                        owner_r    <= OWN_IC;
                        req_r      <= 1'b0;
                        addr_r     <= ic_addr;
                        len_r      <= BURST_LEN;
                        wdata_r    <= {DW{1'b0}};
                        wstrb_r    <= {(DW/8){1'b0}};
                        beat_cnt_r <= {LW{1'b0}};
                        state_r    <= ADDR;
                    end else if (gnt_dc_s) begin
                        owner_r    <= OWN_DC;
                        req_r      <= dc_req;
                        addr_r     <= dc_addr;
                        len_r      <= (!dc_req && dc_burst) ? BURST_LEN : 8'd0;
                        wdata_r    <= dc_wdata;
                        wstrb_r    <= dc_wstrb;
                        beat_cnt_r <= {LW{1'b0}};
                        state_r    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_ready) begin
                        state_r <= req_r ? WRESP : RDATA;
                    end
                end
                RDATA: begin
                    if (bus_rvalid) begin
                        beat_cnt_r <= beat_cnt_r + LW'(1);
                        if (bus_rlast) begin
                            state_r    <= IDLE;
                            last_gnt_r <= owner_r;
                        end
                    end
                end
                WRESP: begin
                    if (bus_bvalid) begin
                        state_r    <= IDLE;
                        last_gnt_r <= owner_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ic_ready  = gnt_ic_s;
    assign dc_ready  = gnt_dc_s;
    assign ic_rvalid = (state_r == RDATA) && bus_rvalid && (owner_r == OWN_IC);
    assign dc_rvalid = (state_r == RDATA) && bus_rvalid && (owner_r == OWN_DC);
    assign dc_bvalid = (state_r == WRESP) && bus_bvalid;
    assign bus_valid = (state_r == ADDR);
    assign bus_req   = req_r;
    assign bus_addr  = addr_r;
    assign bus_len   = len_r;
    assign bus_wdata = wdata_r;
    assign bus_wstrb = wstrb_r;

    // A read burst must end exactly on its advertised beat count.
    a_beat_count: assert property (@(posedge clk) disable iff (!rrst_n)
        (state_r == RDATA && bus_rvalid && bus_rlast) |-> (9'(beat_cnt_r) + 9'd1 == 9'(len_r) + 9'd1));

endmodule

// File: tb/tb_ysyx_22040632_mem_arbiter.sv
// Directed bench for the memory arbiter: a per-cycle vector table plus hand-written
// sequences for the write handshake and mid-transaction reset.
module tb_ysyx_22040632_mem_arbiter;

    logic        clk;
    logic        rrst_n;
    logic        ic_valid, ic_ready, ic_rvalid;
    logic [31:0] ic_addr;
    logic        dc_valid, dc_req, dc_burst, dc_ready, dc_rvalid, dc_bvalid;
    logic [31:0] dc_addr;
    logic [63:0] dc_wdata;
    logic [7:0]  dc_wstrb;
    logic        bus_valid, bus_ready, bus_req;
    logic [31:0] bus_addr;
    logic [7:0]  bus_len;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_rvalid, bus_rlast, bus_bvalid;

    int n_vec = 0;
    int n_bad = 0;

    ysyx_22040632_mem_arbiter #(.AW(32), .DW(64), .BEATS(4)) dut (
        .clk(clk), .rrst_n(rrst_n),
        .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rvalid(ic_rvalid),
        .dc_valid(dc_valid), .dc_req(dc_req), .dc_burst(dc_burst), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_ready(dc_ready),
        .dc_rvalid(dc_rvalid), .dc_bvalid(dc_bvalid),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_req(bus_req),
        .bus_addr(bus_addr), .bus_len(bus_len), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_bvalid(bus_bvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_bits : {ic_valid, dc_valid, dc_req, dc_burst, bus_ready, bus_rvalid, bus_rlast, bus_bvalid}
    // exp_bits: {ic_ready, ic_rvalid, dc_ready, dc_rvalid, dc_bvalid, bus_valid, bus_req, 0}
    typedef struct {
        string       name;
        logic [7:0]  in_bits;
        logic [31:0] ic_a;
        logic [31:0] dc_a;
        logic [7:0]  exp_bits;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] obits;
    assign obits = {ic_ready, ic_rvalid, dc_ready, dc_rvalid, dc_bvalid, bus_valid, bus_req, 1'b0};

    function automatic vec_t mk(input string n, input logic [7:0] i, input logic [31:0] ia,
                                input logic [31:0] da, input logic [7:0] e,
                                input logic [31:0] ea, input logic [7:0] el);
        vec_t v;
        v.name = n; v.in_bits = i; v.ic_a = ia; v.dc_a = da;
        v.exp_bits = e; v.exp_addr = ea; v.exp_len = el;
        return v;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] b);
        {ic_valid, dc_valid, dc_req, dc_burst, bus_ready, bus_rvalid, bus_rlast, bus_bvalid} = b;
    endtask

    initial begin
        // Contention straight after reset: IC first, then DC, then IC again.
        vecs.push_back(mk("pair_ic_gnt",  8'b1101_0000, 32'h8000_0100, 32'h8000_0200, 8'b1000_0000, 32'h0, 8'd0));
        vecs.push_back(mk("pair_ic_addr", 8'b0101_1000, 32'h8000_0100, 32'h8000_0200, 8'b0000_0100, 32'h8000_0100, 8'd3));
        for (int b = 0; b < 3; b++)
            vecs.push_back(mk("pair_ic_beat", 8'b0101_0100, 32'h8000_0100, 32'h8000_0200, 8'b0100_0000, 32'h8000_0100, 8'd3));
        vecs.push_back(mk("pair_ic_last", 8'b1101_0110, 32'h8000_0140, 32'h8000_0200, 8'b0100_0000, 32'h8000_0100, 8'd3));
        vecs.push_back(mk("pair_dc_gnt",  8'b1101_0000, 32'h8000_0140, 32'h8000_0200, 8'b0010_0000, 32'h8000_0100, 8'd3));
        vecs.push_back(mk("pair_dc_addr", 8'b1000_1000, 32'h8000_0140, 32'h8000_0200, 8'b0000_0100, 32'h8000_0200, 8'd3));
        for (int b = 0; b < 3; b++)
            vecs.push_back(mk("pair_dc_beat", 8'b1000_0100, 32'h8000_0140, 32'h8000_0200, 8'b0001_0000, 32'h8000_0200, 8'd3));
        vecs.push_back(mk("pair_dc_last", 8'b1000_0110, 32'h8000_0140, 32'h8000_0200, 8'b0001_0000, 32'h8000_0200, 8'd3));
        vecs.push_back(mk("ic2_gnt",      8'b1000_0000, 32'h8000_0140, 32'h8000_0200, 8'b1000_0000, 32'h8000_0200, 8'd3));
        vecs.push_back(mk("ic2_addr_wait",8'b0000_0000, 32'h8000_0140, 32'h8000_0200, 8'b0000_0100, 32'h8000_0140, 8'd3));
        vecs.push_back(mk("ic2_addr_acc", 8'b0000_1000, 32'h8000_0140, 32'h8000_0200, 8'b0000_0100, 32'h8000_0140, 8'd3));
        vecs.push_back(mk("ic2_beat_bv",  8'b0000_0101, 32'h8000_0140, 32'h8000_0200, 8'b0100_0000, 32'h8000_0140, 8'd3));
        for (int b = 0; b < 2; b++)
            vecs.push_back(mk("ic2_beat", 8'b0000_0100, 32'h8000_0140, 32'h8000_0200, 8'b0100_0000, 32'h8000_0140, 8'd3));
        vecs.push_back(mk("ic2_last",     8'b0000_0110, 32'h8000_0140, 32'h8000_0200, 8'b0100_0000, 32'h8000_0140, 8'd3));
        vecs.push_back(mk("ic2_idle",     8'b0000_0000, 32'h8000_0140, 32'h8000_0200, 8'b0000_0000, 32'h8000_0140, 8'd3));
        // IC-only refill at 0x8000_0040 with one cycle of address wait.
        vecs.push_back(mk("ic_gnt",       8'b1000_0000, 32'h8000_0040, 32'h0, 8'b1000_0000, 32'h8000_0140, 8'd3));
        vecs.push_back(mk("ic_addr_wait", 8'b0000_0000, 32'h8000_0040, 32'h0, 8'b0000_0100, 32'h8000_0040, 8'd3));
        vecs.push_back(mk("ic_addr_acc",  8'b0000_1000, 32'h8000_0040, 32'h0, 8'b0000_0100, 32'h8000_0040, 8'd3));
        for (int b = 0; b < 3; b++)
            vecs.push_back(mk("ic_beat", 8'b0000_0100, 32'h8000_0040, 32'h0, 8'b0100_0000, 32'h8000_0040, 8'd3));
        vecs.push_back(mk("ic_last",      8'b0000_0110, 32'h8000_0040, 32'h0, 8'b0100_0000, 32'h8000_0040, 8'd3));
        vecs.push_back(mk("ic_idle",      8'b0000_0000, 32'h8000_0040, 32'h0, 8'b0000_0000, 32'h8000_0040, 8'd3));
        // Stray responses while idle must be dropped.
        vecs.push_back(mk("idle_stray_all", 8'b0000_0111, 32'h0, 32'h0, 8'b0000_0000, 32'h8000_0040, 8'd3));
        vecs.push_back(mk("idle_stray_b",   8'b0000_0001, 32'h0, 32'h0, 8'b0000_0000, 32'h8000_0040, 8'd3));
        vecs.push_back(mk("idle_stray_r",   8'b0000_0100, 32'h0, 32'h0, 8'b0000_0000, 32'h8000_0040, 8'd3));
        // Uncached single-beat DC read.
        vecs.push_back(mk("unc_gnt",  8'b0100_0000, 32'h0, 32'hA000_0000, 8'b0010_0000, 32'h8000_0040, 8'd3));
        vecs.push_back(mk("unc_addr", 8'b0000_1000, 32'h0, 32'hA000_0000, 8'b0000_0100, 32'hA000_0000, 8'd0));
        vecs.push_back(mk("unc_beat", 8'b0000_0110, 32'h0, 32'hA000_0000, 8'b0001_0000, 32'hA000_0000, 8'd0));
        vecs.push_back(mk("unc_idle", 8'b0000_0000, 32'h0, 32'hA000_0000, 8'b0000_0000, 32'hA000_0000, 8'd0));

        rrst_n = 1'b0;
        drive(8'b0);
        ic_addr = 32'h0; dc_addr = 32'h0; dc_wdata = 64'h0; dc_wstrb = 8'h0;
        #3;
        chk("reset_ctl",   64'({obits, bus_len, bus_addr}), 64'd0);
        chk("reset_wdata", bus_wdata, 64'd0);
        chk("reset_wstrb", 64'(bus_wstrb), 64'd0);
        #9 rrst_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            ic_addr = vecs[k].ic_a;
            dc_addr = vecs[k].dc_a;
            drive(vecs[k].in_bits);
            #4;
            chk(vecs[k].name, 64'({obits, bus_len, bus_addr}),
                64'({vecs[k].exp_bits, vecs[k].exp_len, vecs[k].exp_addr}));
            tick();
        end

        // DC write with the bus stalling the address phase for three cycles.
        dc_addr = 32'h8000_0010; dc_wdata = 64'h11223344_00000000; dc_wstrb = 8'hF0;
        drive(8'b0110_0000);
        #4 chk("wr_ready", 64'(dc_ready), 64'd1);
        tick();
        drive(8'b0);
        dc_wdata = 64'hDEAD_BEEF_DEAD_BEEF; dc_wstrb = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("wr_hold_ctl", 64'({bus_valid, bus_req, bus_len, bus_addr}), 64'({1'b1, 1'b1, 8'd0, 32'h8000_0010}));
            chk("wr_hold_data", bus_wdata, 64'h11223344_00000000);
            chk("wr_hold_strb", 64'(bus_wstrb), 64'hF0);
            tick();
        end
        drive(8'b0000_1000);
        #4 chk("wr_accept", 64'(bus_valid), 64'd1);
        tick();
        drive(8'b0);
        #4 chk("wr_wait", 64'({bus_valid, dc_bvalid}), 64'd0);
        tick();
        drive(8'b0000_0101);
        #4 chk("wr_bvalid", 64'({dc_bvalid, dc_rvalid}), 64'b10);
        tick();
        drive(8'b0);
        #4 chk("wr_done", 64'({bus_valid, dc_bvalid}), 64'd0);
        tick();

        // Reset in the middle of an IC refill, during the second beat.
        ic_addr = 32'h8000_0080;
        drive(8'b1000_0000);
        #4 chk("rst_ic_ready", 64'(ic_ready), 64'd1);
        tick();
        drive(8'b0000_1000);
        tick();
        drive(8'b0000_0100);
        #4 chk("rst_beat1", 64'(ic_rvalid), 64'd1);
        tick();
        drive(8'b0000_0100);
        #2 rrst_n = 1'b0;
        #1;
        chk("rst_ctl",   64'({obits, bus_len, bus_addr}), 64'd0);
        chk("rst_wstrb", 64'(bus_wstrb), 64'd0);
        drive(8'b0);
        @(posedge clk);
        #1 rrst_n = 1'b1;
        tick();

        // A DC burst read after the abandoned refill completes normally.
        dc_addr = 32'h8000_0300;
        drive(8'b0101_0000);
        #4 chk("post_rst_dc_ready", 64'({ic_ready, dc_ready}), 64'b01);
        tick();
        drive(8'b0000_1000);
        #4 chk("post_rst_dc_addr", 64'({bus_valid, bus_req, bus_len, bus_addr}), 64'({1'b1, 1'b0, 8'd3, 32'h8000_0300}));
        tick();
        for (int i = 0; i < 4; i++) begin
            drive((i == 3) ? 8'b0000_0110 : 8'b0000_0100);
            #4 chk("post_rst_dc_beat", 64'({ic_rvalid, dc_rvalid}), 64'b01);
            tick();
        end
        drive(8'b0000_0100);
        #4 chk("post_rst_idle", 64'({bus_valid, ic_rvalid, dc_rvalid}), 64'd0);
        tick();
        drive(8'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
